// File: rtl/cla_pipe_pkg.sv
// cla_pipe_pkg: shared types and constants for the pipelined carry-lookahead adder
package cla_pipe_pkg;
  localparam int GROUP_W = 4;
  typedef enum logic {OP_ADD, OP_SUB} op_t;
  typedef struct packed {
    logic v;
    logic sub;
    logic c;
    logic ov;
  } stage_t;
endpackage

// File: rtl/cla_pipe_if.sv
// cla_pipe_if: operand/result valid-ready bundle for cla_pipe_adder
interface cla_pipe_if import cla_pipe_pkg::*; #(parameter int WIDTH = 8);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic c_in;
  op_t op;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] s_out;
  logic c_out;
  logic ovf;
  modport master (output in_valid, a_in, b_in, c_in, op, out_ready,
                  input in_ready, out_valid, s_out, c_out, ovf);
  modport slave (input in_valid, a_in, b_in, c_in, op, out_ready,
                 output in_ready, out_valid, s_out, c_out, ovf);
endinterface

// File: rtl/cla4_group.sv
// cla4_group: combinational 4-bit carry-lookahead group
module cla4_group (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);
  logic [3:0] g, p;
  logic [4:0] c;
  assign g = a_i & b_i;
  assign p = a_i ^ b_i;
  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & cin_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (&p & cin_i);
  assign sum_o = p ^ c[3:0];
  assign cout_o = c[4];
endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: add/sub resolving one 4-bit lookahead group per pipeline stage, global stall.
// Define CLA_PIPE_SAT_EN for unsigned saturation of the final result.
module cla_pipe_adder import cla_pipe_pkg::*; #(parameter int WIDTH = 8) (
  input logic clk,
  input logic reset,
  cla_pipe_if.slave io
);
  localparam int NG = WIDTH / GROUP_W;
  stage_t ctl_q [0:NG];
  stage_t ctl_d [0:NG];
  logic [WIDTH-1:0] s_q [0:NG];
  logic [WIDTH-1:0] s_d [0:NG];
  logic [WIDTH-1:0] a_q [0:NG-1];
  logic [WIDTH-1:0] a_d [0:NG-1];
  logic [WIDTH-1:0] b_q [0:NG-1];
  logic [WIDTH-1:0] b_d [0:NG-1];
  logic [GROUP_W-1:0] gs [1:NG];
  logic gc [1:NG];
  logic adv;
  logic sub;
  assign adv = !ctl_q[NG].v || io.out_ready;
  assign sub = io.op == OP_SUB;
  assign io.in_ready = adv;
  assign io.out_valid = ctl_q[NG].v;
  assign io.s_out = s_q[NG];
  assign io.c_out = ctl_q[NG].c;
  assign io.ovf = ctl_q[NG].ov;
  for (genvar g = 1; g <= NG; g++) begin : g_grp
    cla4_group u_grp (
      .a_i(a_q[g-1][GROUP_W*g-GROUP_W +: GROUP_W]),
      .b_i(b_q[g-1][GROUP_W*g-GROUP_W +: GROUP_W]),
      .cin_i(ctl_q[g-1].c),
      .sum_o(gs[g]),
      .cout_o(gc[g])
    );
  end
  // the ov field holds the MSB-of-group overflow; only the last stage's value is meaningful
  always_comb begin
    a_d[0] = io.a_in;
    b_d[0] = sub ? ~io.b_in : io.b_in;
    s_d[0] = '0;
    ctl_d[0] = '{v: io.in_valid, sub: sub, c: sub | io.c_in, ov: 1'b0};
    for (int k = 1; k < NG; k++) begin
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
    end
    for (int k = 1; k <= NG; k++) begin
      s_d[k] = s_q[k-1];
      s_d[k][GROUP_W*k-GROUP_W +: GROUP_W] = gs[k];
      ctl_d[k] = '{v: ctl_q[k-1].v, sub: ctl_q[k-1].sub, c: gc[k],
                   ov: gs[k][GROUP_W-1] ^ a_q[k-1][GROUP_W*k-1] ^ b_q[k-1][GROUP_W*k-1] ^ gc[k]};
    end
`ifdef CLA_PIPE_SAT_EN
    if (ctl_d[NG].sub ? !ctl_d[NG].c : ctl_d[NG].c) s_d[NG] = {WIDTH{!ctl_d[NG].sub}};
`endif
  end
  always_ff @(posedge clk)
    if (reset) begin
      for (int k = 0; k <= NG; k++) begin
        ctl_q[k] <= '0;
        s_q[k] <= '0;
      end
      for (int k = 0; k < NG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else if (adv) begin
      ctl_q <= ctl_d;
      s_q <= s_d;
      a_q <= a_d;
      b_q <= b_d;
    end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: directed WIDTH=8 checks plus randomized WIDTH=16 run against an arithmetic model
module tb_cla_pipe_adder;
  import cla_pipe_pkg::*;
  typedef struct {
    logic [15:0] s;
    logic c;
    logic ov;
    int cyc;
  } exp_t;
`ifdef CLA_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q[$];

  cla_pipe_if #(.WIDTH(8)) if8 ();
  cla_pipe_if #(.WIDTH(16)) if16 ();
  cla_pipe_adder #(.WIDTH(8)) u8 (.clk(clk), .reset(reset), .io(if8.slave));
  cla_pipe_adder #(.WIDTH(16)) u16 (.clk(clk), .reset(reset), .io(if16.slave));

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(int w, logic [15:0] a, logic [15:0] b, logic cin, logic sub);
    longint unsigned m, full;
    longint sa, sb, r, lim;
    exp_t e;
    m = (64'd1 << w) - 64'd1;
    full = sub ? 64'(a) + (m - 64'(b)) + 64'd1 : 64'(a) + 64'(b) + 64'(cin);
    e.s = 16'(full & m);
    e.c = ((full >> w) & 64'd1) != 64'd0;
    lim = longint'(m >> 1);
    sa = a[w-1] ? longint'(a) - lim * 2 - 2 : longint'(a);
    sb = b[w-1] ? longint'(b) - lim * 2 - 2 : longint'(b);
    r = sub ? sa - sb : sa + sb + longint'(cin);
    e.ov = (r > lim) || (r < -lim - 1);
    if (SAT && (sub ? !e.c : e.c)) e.s = sub ? 16'h0 : 16'(m);
    e.cyc = 0;
    return e;
  endfunction

  task automatic drive8(logic [7:0] a, logic [7:0] b, logic cin, logic sub);
    if8.in_valid = 1'b1;
    if8.a_in = a;
    if8.b_in = b;
    if8.c_in = cin;
    if8.op = sub ? OP_SUB : OP_ADD;
  endtask

  task automatic lat8(string tag, logic [7:0] a, logic [7:0] b, logic cin, logic sub,
                      logic [7:0] es, logic ec, logic eov);
    int n = 0;
    @(negedge clk);
    if8.out_ready = 1'b1;
    drive8(a, b, cin, sub);
    do begin
      @(negedge clk);
      if8.in_valid = 1'b0;
      n++;
    end while (!if8.out_valid && n < 10);
    chk({tag, "_lat"}, 64'(n - 1), 64'd2);
    chk({tag, "_s"}, 64'(if8.s_out), 64'(es));
    chk({tag, "_c"}, 64'(if8.c_out), 64'(ec));
    chk({tag, "_ovf"}, 64'(if8.ovf), 64'(eov));
  endtask

  task automatic run16(int beats, int pv, int pr, bit chk_lat);
    int sent = 0;
    int guard = 0;
    bit ov_now;
    exp_t e;
    while ((sent < beats || q.size() > 0) && guard < beats * 20 + 100) begin
      @(negedge clk);
      guard++;
      cyc++;
      ov_now = if16.out_valid;
      if (ov_now) begin
        if (q.size() == 0) chk("r16_spurious", 64'(if16.out_valid), 64'd0);
        else begin
          chk("r16_s", 64'(if16.s_out), 64'(q[0].s));
          chk("r16_c", 64'(if16.c_out), 64'(q[0].c));
          chk("r16_ovf", 64'(if16.ovf), 64'(q[0].ov));
          if (chk_lat) chk("r16_lat", 64'(cyc - q[0].cyc - 1), 64'd4);
        end
      end
      if16.out_ready = ($urandom % 100) < pr;
      if16.in_valid = (sent < beats) && (($urandom % 100) < pv);
      if16.a_in = 16'($urandom);
      if16.b_in = 16'($urandom);
      if16.c_in = 1'($urandom);
      if16.op = $urandom_range(0, 1) == 1 ? OP_SUB : OP_ADD;
      #1;
      chk("r16_in_ready", 64'(if16.in_ready), 64'(!ov_now || if16.out_ready));
      if (ov_now && if16.out_ready && q.size() > 0) void'(q.pop_front());
      if (if16.in_valid && if16.in_ready) begin
        e = model(16, if16.a_in, if16.b_in, if16.c_in, if16.op == OP_SUB);
        e.cyc = cyc;
        q.push_back(e);
        sent++;
      end
    end
    if16.in_valid = 1'b0;
    chk("r16_drained", 64'(q.size()), 64'd0);
    chk("r16_all_sent", 64'(sent), 64'(beats));
  endtask

  initial begin
    if8.out_ready = 1'b0;
    drive8(8'hAA, 8'h55, 1'b1, 1'b0);
    if16.in_valid = 1'b1;
    if16.out_ready = 1'b0;
    if16.a_in = 16'h1234;
    if16.b_in = 16'h4321;
    if16.c_in = 1'b0;
    if16.op = OP_ADD;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    if8.in_valid = 1'b0;
    if16.in_valid = 1'b0;
    chk("rst_out_valid", 64'(if8.out_valid), 64'd0);
    chk("rst_s_out", 64'(if8.s_out), 64'd0);
    chk("rst_c_out", 64'(if8.c_out), 64'd0);
    chk("rst_ovf", 64'(if8.ovf), 64'd0);
    chk("rst_in_ready", 64'(if8.in_ready), 64'd1);
    chk("rst16_out_valid", 64'(if16.out_valid), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_capture", 64'(if8.out_valid), 64'd0);
    end
    lat8("ff_plus_1", 8'hFF, 8'h01, 1'b0, 1'b0, SAT ? 8'hFF : 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    chk("ff_plus_1_once", 64'(if8.out_valid), 64'd0);
    lat8("7f_plus_1", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    lat8("5_minus_7", 8'h05, 8'h07, 1'b0, 1'b1, SAT ? 8'h00 : 8'hFE, 1'b0, 1'b0);
    lat8("80_minus_1", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    lat8("add_cin", 8'h3C, 8'h43, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);
    @(negedge clk);
    if8.out_ready = 1'b0;
    drive8(8'h01, 8'h02, 1'b0, 1'b0);
    @(negedge clk);
    drive8(8'h10, 8'h20, 1'b0, 1'b0);
    @(negedge clk);
    drive8(8'h50, 8'h10, 1'b0, 1'b1);
    @(negedge clk);
    if8.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_valid", 64'(if8.out_valid), 64'd1);
      chk("stall_in_ready", 64'(if8.in_ready), 64'd0);
      chk("stall_s", 64'(if8.s_out), 64'h03);
    end
    if8.out_ready = 1'b1;
    @(negedge clk);
    chk("drain2_valid", 64'(if8.out_valid), 64'd1);
    chk("drain2_s", 64'(if8.s_out), 64'h30);
    @(negedge clk);
    chk("drain3_valid", 64'(if8.out_valid), 64'd1);
    chk("drain3_s", 64'(if8.s_out), 64'h40);
    chk("drain3_c", 64'(if8.c_out), 64'd1);
    @(negedge clk);
    chk("drain_done", 64'(if8.out_valid), 64'd0);
    @(negedge clk);
    drive8(8'h11, 8'h22, 1'b0, 1'b0);
    @(negedge clk);
    drive8(8'h33, 8'h44, 1'b0, 1'b0);
    @(negedge clk);
    if8.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_valid", 64'(if8.out_valid), 64'd0);
    chk("mid_rst_s", 64'(if8.s_out), 64'd0);
    chk("mid_rst_c", 64'(if8.c_out), 64'd0);
    chk("mid_rst_ovf", 64'(if8.ovf), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_flushed", 64'(if8.out_valid), 64'd0);
    end
    lat8("post_rst", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0);
    run16(2000, 70, 100, 1'b1);
    run16(10000, 60, 60, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
